// File: rtl/pes_ic_param.sv
// Interrupt controller with round-robin or fixed-priority arbitration. A request reaches intr_out
// one cycle later, the vector follows the first ack and service the second; requests wait while busy.
module pes_ic_param #(
  parameter int NUM_CH = 8,
  parameter int ID_W = 3,
  parameter int VEC_W = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h58
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] intr_rq,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ID_W-1:0]   cmd_data,
  input  logic              intr_in,
  output logic              intr_out,
  output logic [VEC_W-1:0]  vec_out,
  output logic              bus_oe,
  output logic              in_service,
  output logic              err_flag
);

  localparam logic [1:0] OP_MODE = 2'b00;
  localparam logic [1:0] OP_PRIO = 2'b01;
  localparam logic [1:0] OP_MASK = 2'b10;
  localparam logic [1:0] OP_EOI  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, VEC, SERVICE} state_t;

  state_t            state;
  logic              mode;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] pending;
  logic [ID_W-1:0]   prio [NUM_CH];
  logic [ID_W-1:0]   last_served;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_id;
  logic              grant_vld;
  logic              ack;
  logic              eoi;
  logic              eoi_ok;

  assign ack    = ~intr_in;
  assign eoi    = cmd_valid && (cmd_op == OP_EOI);
  assign eoi_ok = eoi && (state == SERVICE) && (cmd_id == sel_id);

  // Loops run from the lowest-precedence candidate upward so the last hit is the winner.
  always_comb begin
    pending   = intr_rq & ~mask;
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    if (!mode) begin
      for (int k = NUM_CH; k >= 1; k--) begin
        scan_id = last_served + ID_W'(k);
        if (pending[scan_id]) begin
          grant_vld = 1'b1;
          grant_id  = scan_id;
        end
      end
    end else begin
      for (int r = NUM_CH - 1; r >= 0; r--) begin
        if (pending[prio[r]]) begin
          grant_vld = 1'b1;
          grant_id  = prio[r];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      mode        <= 1'b0;
      mask        <= '0;
      last_served <= ID_W'(NUM_CH - 1);
      sel_id      <= '0;
      intr_out    <= 1'b0;
      bus_oe      <= 1'b0;
      vec_out     <= '0;
      in_service  <= 1'b0;
      err_flag    <= 1'b0;
      for (int r = 0; r < NUM_CH; r++) prio[r] <= ID_W'(r);
    end else begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_MODE: mode <= cmd_data[0];
          OP_PRIO: prio[cmd_data] <= cmd_id;
          OP_MASK: mask[cmd_id] <= cmd_data[0];
          default: ;
        endcase
      end
      if (eoi && !eoi_ok) err_flag <= 1'b1;
      if (ack && (state == IDLE || state == SERVICE)) err_flag <= 1'b1;

      case (state)
        IDLE: if (grant_vld) begin
          sel_id   <= grant_id;
          intr_out <= 1'b1;
          state    <= REQ;
        end
        REQ: if (ack) begin
          intr_out <= 1'b0;
          bus_oe   <= 1'b1;
          vec_out  <= {VEC_BASE[VEC_W-1:ID_W], sel_id};
          state    <= VEC;
        end
        VEC: if (ack) begin
          bus_oe      <= 1'b0;
          vec_out     <= '0;
          in_service  <= 1'b1;
          last_served <= sel_id;
          state       <= SERVICE;
        end
        SERVICE: if (eoi_ok) begin
          in_service <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pes_ic_param.sv
// Directed and randomized bench for pes_ic_param against a rule-level reference model.
module tb_pes_ic_param;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] intr_rq;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_id;
  logic [2:0] cmd_data;
  logic       intr_in;
  logic       intr_out;
  logic [7:0] vec_out;
  logic       bus_oe;
  logic       in_service;
  logic       err_flag;

  int checks = 0;
  int failures = 0;

  // reference model of the architectural state
  bit         m_mode;
  logic [7:0] m_mask;
  int         m_prio [8];
  int         m_last;
  bit         m_err;
  bit         m_insvc;
  int         m_sel;

  pes_ic_param #(.NUM_CH(8), .ID_W(3), .VEC_W(8), .VEC_BASE(8'h58)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .intr_rq(intr_rq), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_data(cmd_data), .intr_in(intr_in),
    .intr_out(intr_out), .vec_out(vec_out), .bus_oe(bus_oe),
    .in_service(in_service), .err_flag(err_flag)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_mask = '0; m_last = 7; m_err = 0; m_insvc = 0; m_sel = 0;
    for (int r = 0; r < 8; r++) m_prio[r] = r;
  endtask

  function automatic int model_grant(input logic [7:0] pend);
    if (!m_mode) begin
      for (int k = 1; k <= 8; k++) if (pend[(m_last + k) % 8]) return (m_last + k) % 8;
    end else begin
      for (int r = 0; r < 8; r++) if (pend[m_prio[r]]) return m_prio[r];
    end
    return -1;
  endfunction

  task automatic cmd(input logic [1:0] op, input int id, input int data);
    cmd_valid = 1; cmd_op = op; cmd_id = 3'(id); cmd_data = 3'(data);
    tick();
    cmd_valid = 0;
    case (op)
      2'd0: m_mode = data[0];
      2'd1: m_prio[data] = id;
      2'd2: m_mask[id] = data[0];
      default: if (m_insvc && id == m_sel) m_insvc = 0; else m_err = 1;
    endcase
  endtask

  // Wait for intr_out, run both acks, check vector timing, then drop the served request.
  task automatic ack_phase(input int exp_id, input string tag);
    int n = 0;
    while (intr_out !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_intr_out"}, intr_out, 1);
    chk({tag, "_oe_before"}, bus_oe, 0);
    intr_in = 0; tick(); intr_in = 1;
    chk({tag, "_oe_on"}, bus_oe, 1);
    chk({tag, "_intr_off"}, intr_out, 0);
    chk({tag, "_vec"}, vec_out, 8'h58 | exp_id);
    tick();
    chk({tag, "_oe_hold"}, bus_oe, 1);
    intr_in = 0; tick(); intr_in = 1;
    chk({tag, "_oe_off"}, bus_oe, 0);
    chk({tag, "_insvc"}, in_service, 1);
    intr_rq[exp_id] = 1'b0;
    m_last = exp_id; m_sel = exp_id; m_insvc = 1;
  endtask

  task automatic serve(input int exp_id, input string tag);
    ack_phase(exp_id, tag);
    cmd(2'd3, exp_id, 0);
    chk({tag, "_eoi"}, in_service, 0);
    chk({tag, "_err"}, err_flag, m_err);
  endtask

  initial begin
    int exp;
    int tbl [8] = '{5, 3, 7, 0, 4, 2, 6, 1};
    int rr_a [4] = '{1, 3, 5, 7};
    int rr_b [4] = '{0, 2, 4, 6};
    int pr [5] = '{5, 3, 7, 0, 4};
    bit saw;

    rst_in = 1; intr_rq = '0; cmd_valid = 0; cmd_op = '0; cmd_id = '0; cmd_data = '0; intr_in = 1;
    model_reset();
    tick(); tick();
    chk("rst_intr_out", intr_out, 0);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_in_service", in_service, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_vec", vec_out, 0);
    rst_in = 0;
    tick();

    // Round-robin polling
    intr_rq = 8'hAA;
    tick();
    chk("rr_latency", intr_out, 1);
    for (int i = 0; i < 4; i++) serve(rr_a[i], "rr_aa");
    intr_rq = 8'h55;
    for (int i = 0; i < 4; i++) serve(rr_b[i], "rr_55");
    intr_rq = '0;

    // Programmable priority
    cmd(2'd0, 0, 1);
    for (int r = 0; r < 8; r++) cmd(2'd1, tbl[r], r);
    intr_rq = 8'hFF;
    for (int i = 0; i < 4; i++) serve(pr[i], "prio");
    intr_rq[3] = 1'b1;
    serve(3, "prio_reraise");
    serve(4, "prio_after");
    intr_rq = '0;

    // Masking
    cmd(2'd0, 0, 0);
    cmd(2'd2, 1, 1);
    intr_rq = 8'h02;
    saw = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (intr_out) saw = 1; end
    chk("mask_hold", saw, 0);
    cmd(2'd2, 1, 0);
    chk("unmask_edge", intr_out, 0);
    tick();
    chk("unmask_next", intr_out, 1);
    serve(1, "unmask");
    intr_rq = '0;

    // Randomized configuration and requests
    for (int it = 0; it < 40; it++) begin
      cmd(2'd0, 0, $urandom_range(0, 1));
      for (int j = 0; j < 2; j++) cmd(2'd2, $urandom_range(0, 7), $urandom_range(0, 1));
      for (int j = 0; j < 3; j++) cmd(2'd1, $urandom_range(0, 7), $urandom_range(0, 7));
      intr_rq = 8'($urandom);
      exp = model_grant(intr_rq & ~m_mask);
      if (exp < 0) begin
        repeat (3) tick();
        chk("rand_nogrant", intr_out, 0);
      end else begin
        serve(exp, "rand");
      end
      intr_rq = '0;
    end

    // Protocol errors
    cmd(2'd0, 0, 0);
    cmd(2'd2, 2, 0);
    intr_rq = 8'h04;
    ack_phase(2, "perr");
    chk("perr_err_before", err_flag, 0);
    cmd(2'd3, 4, 0);
    chk("perr_wrong_eoi_svc", in_service, 1);
    chk("perr_wrong_eoi_err", err_flag, 1);
    cmd(2'd3, 2, 0);
    chk("perr_good_eoi_svc", in_service, 0);
    chk("perr_sticky", err_flag, 1);
    intr_rq = '0;

    // Reset while presenting the vector
    cmd(2'd0, 0, 1);
    for (int r = 0; r < 8; r++) cmd(2'd1, 0, r);
    cmd(2'd2, 0, 0);
    intr_rq = 8'h01;
    tick();
    chk("rv_req", intr_out, 1);
    intr_in = 0; tick(); intr_in = 1;
    chk("rv_vec_state", bus_oe, 1);
    rst_in = 1;
    #2;
    chk("rv_async_oe", bus_oe, 0);
    chk("rv_async_intr", intr_out, 0);
    chk("rv_async_err", err_flag, 0);
    tick();
    rst_in = 0;
    model_reset();
    intr_rq = 8'h80;
    serve(7, "post_rst");
    intr_rq = '0;

    // EOI and stray ack in the same cycle
    intr_rq = 8'h08;
    exp = model_grant(intr_rq & ~m_mask);
    ack_phase(exp, "simul");
    intr_rq = '0;
    cmd_valid = 1; cmd_op = 2'd3; cmd_id = 3'(exp); intr_in = 0;
    tick();
    cmd_valid = 0; intr_in = 1;
    m_insvc = 0; m_err = 1;
    chk("simul_eoi", in_service, 0);
    chk("simul_err", err_flag, m_err);
    tick();
    chk("simul_idle", intr_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
